// File: rtl/pwm_speed_pkg.sv
// rtl/pwm_speed_pkg.sv - shared constants for the PWM speed command stage
//
// Purpose : default speed-code width, its maximum code, and the ramp FSM
//           state encoding used by pwm_speed_ramp.
// Ports   : none (package).
package pwm_speed_pkg;

  localparam int SPEED_W_DEF = 3;
  localparam logic [SPEED_W_DEF-1:0] SPEED_MAX = '1;

  // Ramp FSM encoding
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RAMP = 1'b1;

endpackage

// File: rtl/btn_debounce.sv
// rtl/btn_debounce.sv - button synchroniser, debouncer and press-pulse generator
//
// Purpose : brings a raw asynchronous button into the clk domain (2-FF),
//           debounces it, and emits a one-cycle pulse on each debounced rise.
//           Press-to-pulse latency is 2 + DEB_CYCLES + 1 cycles.
// Ports   : clk   - clock
//           rst   - asynchronous active-high reset
//           btn   - raw button input
//           pulse - one-cycle pulse per debounced press
module btn_debounce #(
  parameter int DEB_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic pulse
);

  localparam int DW = $clog2(DEB_CYCLES);
  localparam logic [DW-1:0] DEB_LAST = DW'(DEB_CYCLES - 1);

  logic          sync1;
  logic          sync2;
  logic          level;
  logic          level_d;
  logic [DW-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1   <= 1'b0;
      sync2   <= 1'b0;
      level   <= 1'b0;
      level_d <= 1'b0;
      cnt     <= '0;
      pulse   <= 1'b0;
    end else begin
      sync1   <= btn;
      sync2   <= sync1;
      // cnt holds the number of consecutive cycles the synced input has
      // disagreed with the debounced level; any agreement starts over.
      if (sync2 == level) begin
        cnt <= '0;
      end else if (cnt == DEB_LAST) begin
        level <= sync2;
        cnt   <= '0;
      end else begin
        cnt <= cnt + DW'(1);
      end
      level_d <= level;
      pulse   <= level & ~level_d;
    end
  end

endmodule

// File: rtl/pwm_speed_ramp.sv
// rtl/pwm_speed_ramp.sv - button-driven saturating speed target with ramped output
//
// Purpose : up/down buttons adjust a saturating target code; speed walks
//           toward target one code per RAMP_TICKS enabled cycles.
//           Build macro SPEED_RAMP_EN: defined -> ramp; undefined -> speed
//           follows target one clock later with no tick counter.
// Ports   : clk, rst (async active-high), enable (0 freezes target/ramp),
//           btn_up, btn_down (raw), speed, target (SPEED_W codes),
//           busy (speed still converging), step (pulse when speed changes)
module pwm_speed_ramp
  import pwm_speed_pkg::*;
#(
  parameter int SPEED_W    = SPEED_W_DEF,
  parameter int DEB_CYCLES = 16,
  parameter int RAMP_TICKS = 1000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enable,
  input  logic               btn_up,
  input  logic               btn_down,
  output logic [SPEED_W-1:0] speed,
  output logic [SPEED_W-1:0] target,
  output logic               busy,
  output logic               step
);

  localparam logic [SPEED_W-1:0] CODE_MAX = '1;

  logic               up_pulse;
  logic               down_pulse;
  logic [SPEED_W-1:0] target_next;

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_up (
    .clk   (clk),
    .rst   (rst),
    .btn   (btn_up),
    .pulse (up_pulse)
  );

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_down (
    .clk   (clk),
    .rst   (rst),
    .btn   (btn_down),
    .pulse (down_pulse)
  );

  // Saturation is checked before the +-1 so the code never wraps.
  always_comb begin
    target_next = target;
    if (enable && up_pulse && !down_pulse && target != CODE_MAX)
      target_next = target + SPEED_W'(1);
    else if (enable && down_pulse && !up_pulse && target != '0)
      target_next = target - SPEED_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) target <= '0;
    else     target <= target_next;
  end

`ifdef SPEED_RAMP_EN
  localparam int CNT_W = (RAMP_TICKS > 1) ? $clog2(RAMP_TICKS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RAMP_TICKS - 1);

  logic [0:0]         state;
  logic [0:0]         state_next;
  logic [CNT_W-1:0]   cnt;
  logic [CNT_W-1:0]   cnt_next;
  logic [SPEED_W-1:0] speed_next;
  logic               step_next;

  // Direction and the IDLE/RAMP decision both use target_next, so a target
  // change landing on the same edge as a tick is honoured immediately and
  // entering RAMP coincides with the target update.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    speed_next = speed;
    step_next  = 1'b0;
    if (enable) begin
      if (state == ST_RAMP) begin
        if (cnt == CNT_LAST) begin
          cnt_next = '0;
          if (speed < target_next) begin
            speed_next = speed + SPEED_W'(1);
            step_next  = 1'b1;
          end else if (speed > target_next) begin
            speed_next = speed - SPEED_W'(1);
            step_next  = 1'b1;
          end
        end else begin
          cnt_next = cnt + CNT_W'(1);
        end
      end
      if (speed_next != target_next) begin
        state_next = ST_RAMP;
      end else begin
        state_next = ST_IDLE;
        cnt_next   = '0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      cnt   <= '0;
      speed <= '0;
      step  <= 1'b0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      speed <= speed_next;
      step  <= step_next;
    end
  end

  assign busy = (state == ST_RAMP);
`else
  logic unused_ramp_cfg;
  assign unused_ramp_cfg = (RAMP_TICKS != 0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      speed <= '0;
      step  <= 1'b0;
    end else if (enable) begin
      speed <= target;
      step  <= (speed != target);
    end else begin
      step  <= 1'b0;
    end
  end

  assign busy = (speed != target);
`endif

endmodule

// File: tb/tb_pwm_speed_ramp.sv
// tb/tb_pwm_speed_ramp.sv - self-checking bench for pwm_speed_ramp
module tb_pwm_speed_ramp;

  localparam int SW   = 3;
  localparam int DEB  = 4;
  localparam int RAMP = 8;
  localparam int SMAX = 7;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          enable = 1'b0;
  logic          btn_up = 1'b0;
  logic          btn_down = 1'b0;
  logic [SW-1:0] speed;
  logic [SW-1:0] target;
  logic          busy;
  logic          step;

  pwm_speed_ramp #(.SPEED_W(SW), .DEB_CYCLES(DEB), .RAMP_TICKS(RAMP)) dut (
    .clk      (clk),
    .rst      (rst),
    .enable   (enable),
    .btn_up   (btn_up),
    .btn_down (btn_down),
    .speed    (speed),
    .target   (target),
    .busy     (busy),
    .step     (step)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
  endtask

  // Reference model: raw-sample windows per button, level histories, and
  // speed/target/busy/step from the stated ramp rules.
  bit hist [2][32];
  bit lvl  [2];
  bit lvlh [2][3];
  int m_speed, m_target, m_elapsed;
  bit m_busy, m_step;

  task automatic model_reset();
    for (int b = 0; b < 2; b++) begin
      for (int i = 0; i < 32; i++) hist[b][i] = 1'b0;
      lvl[b] = 1'b0;
      for (int i = 0; i < 3; i++) lvlh[b][i] = 1'b0;
    end
    m_speed = 0; m_target = 0; m_elapsed = 0; m_busy = 1'b0; m_step = 1'b0;
  endtask

  task automatic model_edge(input bit u, input bit d, input bit e);
    bit p [2];
    bit raw [2];
    bit flip;
    int tn;
    raw[0] = u; raw[1] = d;
    for (int b = 0; b < 2; b++) begin
      // press pulse seen at this edge: debounced level rose two edges ago
      p[b] = lvlh[b][1] & ~lvlh[b][2];
      for (int i = 31; i > 0; i--) hist[b][i] = hist[b][i-1];
      hist[b][0] = raw[b];
      // synced value lags the raw sample by two edges; flip once the last
      // DEB synced values all disagree with the current level
      flip = 1'b1;
      for (int j = 2; j <= DEB + 1; j++) if (hist[b][j] == lvl[b]) flip = 1'b0;
      if (flip) lvl[b] = ~lvl[b];
      lvlh[b][2] = lvlh[b][1];
      lvlh[b][1] = lvlh[b][0];
      lvlh[b][0] = lvl[b];
    end
    tn = m_target;
    if (e && p[0] && !p[1] && m_target < SMAX) tn = m_target + 1;
    else if (e && p[1] && !p[0] && m_target > 0) tn = m_target - 1;
    m_step = 1'b0;
`ifdef SPEED_RAMP_EN
    if (e) begin
      if (m_busy) begin
        m_elapsed++;
        if (m_elapsed == RAMP) begin
          m_elapsed = 0;
          if (m_speed < tn) begin m_speed++; m_step = 1'b1; end
          else if (m_speed > tn) begin m_speed--; m_step = 1'b1; end
        end
      end
      m_busy = (m_speed != tn);
      if (!m_busy) m_elapsed = 0;
    end
    m_target = tn;
`else
    if (e) begin
      m_step  = (m_speed != m_target);
      m_speed = m_target;
    end
    m_target = tn;
    m_busy   = (m_speed != m_target);
`endif
  endtask

  task automatic cyc(input bit u, input bit d, input bit e);
    btn_up = u; btn_down = d; enable = e;
    @(posedge clk);
    #1;
    model_edge(u, d, e);
    chk("speed", int'(speed), m_speed);
    chk("target", int'(target), m_target);
    chk("busy", int'(busy), int'(m_busy));
    chk("step", int'(step), int'(m_step));
  endtask

  task automatic press(input bit u, input bit d);
    repeat (6) cyc(u, d, 1'b1);
    repeat (8) cyc(1'b0, 1'b0, 1'b1);
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(1'b0, 1'b0, 1'b1);
  endtask

  task automatic do_reset();
    #3;
    rst = 1'b1;
    #1;
    chk("rst_speed", int'(speed), 0);
    chk("rst_target", int'(target), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_step", int'(step), 0);
    model_reset();
    btn_up = 1'b0; btn_down = 1'b0;
    @(posedge clk); @(posedge clk);
    #3;
    rst = 1'b0;
  endtask

  int saved;

  initial begin
    model_reset();
    #2;
    chk("por_speed", int'(speed), 0);
    chk("por_target", int'(target), 0);
    chk("por_busy", int'(busy), 0);
    @(posedge clk); #3;
    rst = 1'b0;

    // 1: held press -> single pulse, target 1, then speed 1
    for (int i = 1; i <= 30; i++) begin
      cyc(i <= 20, 1'b0, 1'b1);
      if (i == 7) chk("t1_tgt_before", int'(target), 0);
      if (i == 8) chk("t1_tgt_after", int'(target), 1);
`ifdef SPEED_RAMP_EN
      if (i == 15) chk("t1_spd_before", int'(speed), 0);
      if (i == 16) begin
        chk("t1_spd_step", int'(speed), 1);
        chk("t1_step", int'(step), 1);
      end
`else
      if (i == 9) begin
        chk("t1_spd_step", int'(speed), 1);
        chk("t1_step", int'(step), 1);
      end
`endif
    end
    chk("t1_busy_end", int'(busy), 0);

    // 2: 3-cycle glitch ignored
    repeat (3) cyc(1'b1, 1'b0, 1'b1);
    idle(15);
    chk("t2_glitch", int'(target), 1);

    // 3: saturation at both ends
    repeat (8) press(1'b1, 1'b0);
    chk("t3_sat_hi", int'(target), SMAX);
    idle(60);
    chk("t3_speed_hi", int'(speed), SMAX);
    repeat (8) press(1'b0, 1'b1);
    press(1'b0, 1'b1);
    chk("t3_sat_lo", int'(target), 0);
    idle(60);
    chk("t3_speed_lo", int'(speed), 0);

    // 4: raise to 5 then fall back to 2
    repeat (5) press(1'b1, 1'b0);
    repeat (3) press(1'b0, 1'b1);
    idle(40);
    chk("t4_speed", int'(speed), 2);
    chk("t4_busy", int'(busy), 0);

    // 5: freeze mid-ramp, press during freeze is dropped
    press(1'b1, 1'b0);
    idle(3);
    saved = m_target;
    repeat (6) cyc(1'b1, 1'b0, 1'b0);
    repeat (4) cyc(1'b0, 1'b0, 1'b0);
    chk("t5_tgt_frozen", int'(target), saved);
    idle(40);

    // 6: reset mid-ramp
    repeat (4) press(1'b1, 1'b0);
    do_reset();
    idle(3);
    chk("t6_after_rst", int'(speed), 0);

    // random soak
    for (int s = 0; s < 150; s++) begin
      bit u, d, e;
      int len;
      u   = ($urandom_range(0, 2) == 0);
      d   = ($urandom_range(0, 3) == 0);
      e   = ($urandom_range(0, 6) != 0);
      len = $urandom_range(1, 12);
      repeat (len) cyc(u, d, e);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
